shift_iterative: RTL and testbench

Multi-cycle, parametrised shift/rotate unit for the ALU datapath. It replaces the per-bit combinational shift slices with a single registered engine. The engine processes up to STEP bit positions per clock, supports four shift modes, and uses a start/done handshake. It sits beside the adder/subtractor and the compare units, and its result feeds the ALU output mux.

---
 rtl/shift_iterative_pkg.sv | 17 +
 rtl/shift_iterative_step.sv | 43 ++++
 rtl/shift_iterative.sv | 97 +++++++++
 tb/tb_shift_iterative.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_iterative_pkg.sv
// Shared encodings for the iterative shift/rotate engine: op codes and FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package shift_iterative_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_iterative_step.sv
// One iteration of the shifter: shifts acc by s (0..STEP) positions in the given mode.
// Latency: combinational, log2(STEP)+1 mux stages selected by the bits of s.
// Backpressure: none; pure function of its inputs.
module shift_iterative_step
    import shift_iterative_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SW   = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [SW-1:0]    s,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] res
);

    // Fixed-distance shift used by each stage; d is a per-stage constant after unrolling.
    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] v,
                                                  input logic [1:0] o,
                                                  input int d);
        logic [WIDTH-1:0] r;
        case (o)
            OP_SLL:  r = v << d;
            OP_SRL:  r = v >> d;
            OP_SRA:  r = $signed(v) >>> d;
            default: r = (v << d) | (v >> (WIDTH - d));
        endcase
        return r;
    endfunction

    // Binary-weighted stage chain: stage k shifts by 2^k when s[k] is set.
    always_comb begin
        logic [WIDTH-1:0] v;
        v = acc;
        for (int k = 0; k < SW; k++) begin
            if (s[k]) begin
                v = shift_by(v, op, 1 << k);
            end
        end
        res = v;
    end

endmodule

// File: rtl/shift_iterative.sv
// Multi-cycle shift/rotate engine with start/done handshake, up to STEP bits per cycle.
// Latency: ceil(Y/STEP)+1 cycles from the start edge to done; busy for ceil(Y/STEP)+2 cycles.
// Backpressure: start is ignored (not queued) whenever busy is high, including the done cycle.
module shift_iterative
    import shift_iterative_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    localparam int SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] X,
    input  logic [SHW-1:0]   Y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Z
);

    localparam int SW = $clog2(STEP) + 1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, acc_nx, stepped, z_nx;
    logic [SHW-1:0]   rem, rem_nx;
    logic [1:0]       op_r, op_nx;
    logic             done_nx;
    logic [SW-1:0]    s;

    // Positions consumed this cycle: the remaining count, capped at STEP.
    assign s = (rem > SHW'(STEP)) ? SW'(STEP) : rem[SW-1:0];

    shift_iterative_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .acc (acc),
        .s   (s),
        .op  (op_r),
        .res (stepped)
    );

    assign busy = (state != S_IDLE);

    // Next-state and datapath updates; operands are captured only in IDLE.
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        rem_nx   = rem;
        op_nx    = op_r;
        z_nx     = Z;
        done_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    acc_nx   = X;
                    rem_nx   = Y;
                    op_nx    = op;
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (rem != '0) begin
                    acc_nx = stepped;
                    rem_nx = rem - SHW'(s);
                end else begin
                    z_nx     = acc;
                    done_nx  = 1'b1;
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            acc   <= '0;
            rem   <= '0;
            op_r  <= OP_SLL;
            Z     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            rem   <= rem_nx;
            op_r  <= op_nx;
            Z     <= z_nx;
            done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_shift_iterative.sv
// Bench for shift_iterative: STEP=1 and STEP=4 instances share stimulus, checked each cycle
// against a transaction-level model (capture at accept, result and timing from arithmetic).
module tb_shift_iterative;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] x = '0;
    logic [4:0]  y = '0;
    logic        busy1, done1, busy4, done4;
    logic [31:0] z1, z4;

    always #5 clk = ~clk;

    shift_iterative #(.WIDTH(32), .STEP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .X(x), .Y(y),
        .busy(busy1), .done(done1), .Z(z1)
    );

    shift_iterative #(.WIDTH(32), .STEP(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .X(x), .Y(y),
        .busy(busy4), .done(done4), .Z(z4)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Reference result of one whole shift operation.
    function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] a, input int s);
        logic [31:0] r;
        case (o)
            2'b00:   r = a << s;
            2'b01:   r = a >> s;
            2'b10:   r = $signed(a) >>> s;
            default: r = (s == 0) ? a : ((a << s) | (a >> (32 - s)));
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model per instance (index 0: STEP=1, index 1: STEP=4).
    int          stp [2] = '{1, 4};
    bit          act [2];
    int          t0  [2];
    int          nn  [2];
    logic [31:0] ez  [2];
    logic [31:0] zh  [2];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                act[i] = 1'b0;
                zh[i]  = '0;
            end else begin
                bit was_busy;
                was_busy = act[i] && cyc > t0[i] && cyc <= t0[i] + nn[i] + 2;
                if (act[i] && cyc == t0[i] + nn[i] + 1) zh[i] = ez[i];
                if (act[i] && cyc >= t0[i] + nn[i] + 2) act[i] = 1'b0;
                if (start && !was_busy) begin
                    act[i] = 1'b1;
                    t0[i]  = cyc;
                    nn[i]  = (int'(y) + stp[i] - 1) / stp[i];
                    ez[i]  = ref_shift(op, x, int'(y));
                end
            end
        end
    end

    // Observed done timing / pulse counts used by the directed checks.
    int dcyc [2];
    int dcnt [2];
    int bcnt [2];

    // Per-cycle compare of every output of both instances against the model.
    always @(negedge clk) begin
        logic b [2];
        logic d [2];
        logic [31:0] z [2];
        b[0] = busy1; d[0] = done1; z[0] = z1;
        b[1] = busy4; d[1] = done4; z[1] = z4;
        for (int i = 0; i < 2; i++) begin
            logic eb, ed;
            logic [31:0] ezv;
            eb  = rst_n && act[i] && cyc >= t0[i] && cyc <= t0[i] + nn[i] + 1;
            ed  = rst_n && act[i] && cyc == t0[i] + nn[i] + 1;
            ezv = rst_n ? zh[i] : 32'h0;
            chk($sformatf("busy[step%0d]", stp[i]), {31'b0, b[i]}, {31'b0, eb});
            chk($sformatf("done[step%0d]", stp[i]), {31'b0, d[i]}, {31'b0, ed});
            chk($sformatf("Z[step%0d]", stp[i]), z[i], ezv);
            if (d[i]) begin
                dcyc[i] = cyc;
                dcnt[i]++;
            end
            if (b[i]) bcnt[i]++;
        end
    end

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            dcnt[i] = 0;
            bcnt[i] = 0;
            dcyc[i] = -1;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy1 && !busy4) return;
        end
        checks++;
        fails++;
        $display("FAIL wait_idle: busy still high after 300 cycles (busy1=%b busy4=%b)", busy1, busy4);
    endtask

    // Issue one request while idle; returns the edge index at which start is sampled.
    task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [4:0] s, output int s0);
        clear_counts();
        @(negedge clk);
        op = o; x = a; y = s; start = 1'b1;
        s0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        int s0;
        clear_counts();
        repeat (2) @(negedge clk);
        chk("reset busy1", {31'b0, busy1}, 32'h0);
        chk("reset done1", {31'b0, done1}, 32'h0);
        chk("reset z1", z1, 32'h0);
        rst_n = 1'b1;

        // Long STEP=1 shift: done 32 edges after start, busy 33 cycles.
        go(2'b00, 32'h0000_0001, 5'd31, s0);
        chk("sll31 z1", z1, 32'h8000_0000);
        chk("sll31 z4", z4, 32'h8000_0000);
        chk("sll31 done edge step1", dcyc[0] - s0, 32);
        chk("sll31 busy cycles step1", bcnt[0], 33);
        chk("sll31 done edge step4", dcyc[1] - s0, 9);

        go(2'b10, 32'h8000_0000, 5'd4, s0);
        chk("sra4 z1", z1, 32'hF800_0000);
        chk("sra4 z4", z4, 32'hF800_0000);
        go(2'b01, 32'h8000_0000, 5'd4, s0);
        chk("srl4 z1", z1, 32'h0800_0000);

        go(2'b11, 32'h8000_0001, 5'd1, s0);
        chk("rol1 z4", z4, 32'h0000_0003);
        chk("rol1 z1", z1, 32'h0000_0003);
        go(2'b01, 32'hFFFF_FFFF, 5'd7, s0);
        chk("srl7 z4", z4, 32'h01FF_FFFF);
        chk("srl7 done edge step4", dcyc[1] - s0, 3);

        // Zero shift amount for every mode.
        for (int o = 0; o < 4; o++) begin
            go(2'(o), 32'hDEAD_BEEF, 5'd0, s0);
            chk("y0 z1", z1, 32'hDEAD_BEEF);
            chk("y0 z4", z4, 32'hDEAD_BEEF);
            chk("y0 done edge", dcyc[0] - s0, 1);
        end

        // Operand changes during the shift must not affect the result.
        clear_counts();
        @(negedge clk);
        op = 2'b10; x = 32'h8000_1234; y = 5'd13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) begin
            x = $urandom; op = 2'($urandom_range(0, 3)); y = 5'($urandom_range(0, 31));
            @(negedge clk);
        end
        wait_idle();
        chk("toggle z1", z1, 32'hFFFC_0000);
        chk("toggle z4", z4, 32'hFFFC_0000);

        // start held high with fresh operands throughout, including the done cycle.
        clear_counts();
        @(negedge clk);
        op = 2'b00; x = 32'h0000_0003; y = 5'd5; start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done1) break;
            x = $urandom; op = 2'($urandom_range(0, 3)); y = 5'($urandom_range(0, 31));
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        chk("busy-start z1", z1, 32'h0000_0060);
        chk("busy-start done count", dcnt[0], 1);

        // Asynchronous reset in the middle of a shift.
        clear_counts();
        @(negedge clk);
        op = 2'b00; x = 32'h0000_0001; y = 5'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst busy1", {31'b0, busy1}, 32'h0);
        chk("arst done1", {31'b0, done1}, 32'h0);
        chk("arst z1", z1, 32'h0);
        chk("arst z4", z4, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("arst no done", dcnt[0], 0);
        go(2'b01, 32'h0000_00F0, 5'd4, s0);
        chk("post-reset z1", z1, 32'h0000_000F);
        chk("post-reset z4", z4, 32'h0000_000F);

        // Randomised requests; the per-cycle compare does the checking.
        for (int k = 0; k < 150; k++) begin
            go(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), s0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
